// File: rtl/agc_ctrl_pkg.sv
// AGC loop controller shared types, limits and parameter defaults.
package agc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_TICK,
      ST_MEASURE,
      ST_SETTLE,
      ST_COMPUTE,
      ST_LOAD,
      ST_APPLY
   } agc_state_e;

   localparam logic [16:0]        SCALE_MAX = 17'h1FFFF;
   localparam logic signed [7:0]  OFS_MIN   = -8'sd128;
   localparam logic signed [7:0]  OFS_MAX   = 8'sd127;

   localparam int          WINDOW_LEN_DEF = 131072;
   localparam int          SETTLE_LEN_DEF = 6;
   localparam logic [16:0] SCALE_INIT_DEF = 17'h10000;
   localparam int          SCALE_STEP_DEF = 256;
   localparam int          OFS_TOL_DEF    = 64;

endpackage

// File: rtl/agc_ctrl_if.sv
// Control/status bundle between the AGC loop controller and the signal core.
interface agc_ctrl_if;
   logic        run_i;
   logic        single_i;
   logic [23:0] sq_target_i;
   logic [23:0] sq_tol_i;
   logic [23:0] sq_accum_i;
   logic [20:0] gt_accum_i;
   logic [20:0] lt_accum_i;
   logic        agc_rst_o;
   logic        agc_tick_o;
   logic        agc_ce_o;
   logic [16:0] scale_o;
   logic [7:0]  offset_o;
   logic        scale_ce_o;
   logic        offset_ce_o;
   logic        apply_o;
   logic        busy_o;
   logic        iter_done_o;
   logic        locked_o;

   modport master (
      input  run_i, single_i, sq_target_i, sq_tol_i, sq_accum_i, gt_accum_i, lt_accum_i,
      output agc_rst_o, agc_tick_o, agc_ce_o, scale_o, offset_o, scale_ce_o, offset_ce_o,
             apply_o, busy_o, iter_done_o, locked_o
   );

   modport slave (
      output run_i, single_i, sq_target_i, sq_tol_i, sq_accum_i, gt_accum_i, lt_accum_i,
      input  agc_rst_o, agc_tick_o, agc_ce_o, scale_o, offset_o, scale_ce_o, offset_ce_o,
             apply_o, busy_o, iter_done_o, locked_o
   );
endinterface

// File: rtl/agc_step_calc.sv
// Combinational scale/offset update for one AGC iteration, plus lock status.
module agc_step_calc
   import agc_ctrl_pkg::*;
#(
   parameter int SCALE_STEP = SCALE_STEP_DEF,
   parameter int OFS_TOL    = OFS_TOL_DEF
) (
   input  logic [23:0]       sq_target,
   input  logic [23:0]       sq_tol,
   input  logic [23:0]       sq_accum,
   input  logic [20:0]       gt_accum,
   input  logic [20:0]       lt_accum,
   input  logic [16:0]       scale_cur,
   input  logic signed [7:0] offset_cur,
   output logic [16:0]       scale_nxt,
   output logic signed [7:0] offset_nxt,
   output logic              locked_nxt
);

   localparam logic [16:0] STEP17 = 17'(SCALE_STEP);
   localparam logic [21:0] TOL22  = 22'(OFS_TOL);

   logic [24:0] sq_acc25;
   logic [24:0] sq_hi;
   logic [24:0] sq_lo;
   logic [17:0] scale_up;
   logic [21:0] gt22;
   logic [21:0] lt22;

   // Gain step: compare the square level against a 25-bit deadband, lower edge clamped at 0
   always_comb begin
      sq_acc25  = {1'b0, sq_accum};
      sq_hi     = {1'b0, sq_target} + {1'b0, sq_tol};
      sq_lo     = (sq_target >= sq_tol) ? {1'b0, sq_target - sq_tol} : '0;
      scale_up  = {1'b0, scale_cur} + {1'b0, STEP17};
      scale_nxt = scale_cur;
      if (sq_acc25 > sq_hi) begin
         scale_nxt = (scale_cur < STEP17) ? '0 : scale_cur - STEP17;
      end else if (sq_acc25 < sq_lo) begin
         scale_nxt = (scale_up > {1'b0, SCALE_MAX}) ? SCALE_MAX : scale_up[16:0];
      end
   end

   // Offset step: 22-bit imbalance compare so count+tolerance cannot wrap
   always_comb begin
      gt22       = {1'b0, gt_accum};
      lt22       = {1'b0, lt_accum};
      offset_nxt = offset_cur;
      if (gt22 > lt22 + TOL22) begin
         if (offset_cur != OFS_MIN) offset_nxt = offset_cur - 8'sd1;
      end else if (lt22 > gt22 + TOL22) begin
         if (offset_cur != OFS_MAX) offset_nxt = offset_cur + 8'sd1;
      end
   end

   assign locked_nxt = (scale_nxt == scale_cur) && (offset_nxt == offset_cur);

endmodule

// File: rtl/agc_loop_ctrl.sv
// AGC loop sequencer: measurement window, settle wait, update and apply.
//
//   state   | meaning
//   IDLE    | waiting for run_i or single_i
//   CLR     | clear core accumulators (agc_rst_o)
//   TICK    | mark window start (agc_tick_o)
//   MEASURE | accumulate for WINDOW_LEN cycles (agc_ce_o)
//   SETTLE  | wait SETTLE_LEN cycles for accumulator pipeline
//   COMPUTE | evaluate step; scale/offset/lock registered on exit
//   LOAD    | scale_ce_o / offset_ce_o
//   APPLY   | apply_o, iter_done_o; loop again if run_i
module agc_loop_ctrl
   import agc_ctrl_pkg::*;
#(
   parameter int          WINDOW_LEN = WINDOW_LEN_DEF,
   parameter int          SETTLE_LEN = SETTLE_LEN_DEF,
   parameter logic [16:0] SCALE_INIT = SCALE_INIT_DEF,
   parameter int          SCALE_STEP = SCALE_STEP_DEF,
   parameter int          OFS_TOL    = OFS_TOL_DEF
) (
   input logic        aclk,
   input logic        aresetn,
   agc_ctrl_if.master bus
);

   localparam int             CNT_W       = 21;
   localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WINDOW_LEN - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);

   logic [1:0]        rst_sync;
   logic              rst_n_int;
   agc_state_e        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [16:0]       scale_q, scale_nxt;
   logic signed [7:0] offset_q, offset_nxt;
   logic              locked_q, locked_nxt;

   // Reset asserts immediately, releases two aclk edges after aresetn rises
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_int = rst_sync[1];

   // State register
   always_ff @(posedge aclk or negedge rst_n_int) begin
      if (!rst_n_int) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // Window/settle counter: zeroed on every state change, saturates instead of wrapping
   always_ff @(posedge aclk or negedge rst_n_int) begin
      if (!rst_n_int)               cnt <= '0;
      else if (state != state_nxt)  cnt <= '0;
      else if (cnt != '1)           cnt <= cnt + 1'b1;
   end

   // Next-state and per-state strobes
   always_comb begin
      state_nxt       = state;
      bus.agc_rst_o   = 1'b0;
      bus.agc_tick_o  = 1'b0;
      bus.agc_ce_o    = 1'b0;
      bus.scale_ce_o  = 1'b0;
      bus.offset_ce_o = 1'b0;
      bus.apply_o     = 1'b0;
      bus.iter_done_o = 1'b0;
      bus.busy_o      = (state != ST_IDLE);
      case (state)
         ST_IDLE:    if (bus.run_i || bus.single_i) state_nxt = ST_CLR;
         ST_CLR: begin
            bus.agc_rst_o = 1'b1;
            state_nxt     = ST_TICK;
         end
         ST_TICK: begin
            bus.agc_tick_o = 1'b1;
            state_nxt      = ST_MEASURE;
         end
         ST_MEASURE: begin
            bus.agc_ce_o = 1'b1;
            if (cnt == WIN_LAST) state_nxt = ST_SETTLE;
         end
         ST_SETTLE:  if (cnt == SETTLE_LAST) state_nxt = ST_COMPUTE;
         ST_COMPUTE: state_nxt = ST_LOAD;
         ST_LOAD: begin
            bus.scale_ce_o  = 1'b1;
            bus.offset_ce_o = 1'b1;
            state_nxt       = ST_APPLY;
         end
         ST_APPLY: begin
            bus.apply_o     = 1'b1;
            bus.iter_done_o = 1'b1;
            state_nxt       = bus.run_i ? ST_CLR : ST_IDLE;
         end
         default:    state_nxt = ST_IDLE;
      endcase
   end

   agc_step_calc #(
      .SCALE_STEP (SCALE_STEP),
      .OFS_TOL    (OFS_TOL)
   ) u_step (
      .sq_target  (bus.sq_target_i),
      .sq_tol     (bus.sq_tol_i),
      .sq_accum   (bus.sq_accum_i),
      .gt_accum   (bus.gt_accum_i),
      .lt_accum   (bus.lt_accum_i),
      .scale_cur  (scale_q),
      .offset_cur (offset_q),
      .scale_nxt  (scale_nxt),
      .offset_nxt (offset_nxt),
      .locked_nxt (locked_nxt)
   );

   // Capture the step result on leaving COMPUTE; held through LOAD and APPLY
   always_ff @(posedge aclk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         scale_q  <= SCALE_INIT;
         offset_q <= '0;
         locked_q <= 1'b0;
      end else if (state == ST_COMPUTE) begin
         scale_q  <= scale_nxt;
         offset_q <= offset_nxt;
         locked_q <= locked_nxt;
      end
   end

   assign bus.scale_o  = scale_q;
   assign bus.offset_o = offset_q;
   assign bus.locked_o = locked_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Self-checking bench for agc_loop_ctrl: vector table, randomized model compare, corner sequences.
module tb_agc_loop_ctrl;

   localparam int WLEN     = 16;
   localparam int SLEN     = 6;
   localparam int BUSY_CYC = 2 + WLEN + SLEN + 3;   // CLR,TICK + window + settle + COMPUTE,LOAD,APPLY
   localparam int STEP     = 256;
   localparam int OTOL     = 64;

   logic aclk  = 1'b0;
   logic rst_n = 1'b0;

   agc_ctrl_if m_if ();
   agc_ctrl_if s_if ();

   agc_loop_ctrl #(.WINDOW_LEN(WLEN), .SETTLE_LEN(SLEN)) u_dut (
      .aclk    (aclk),
      .aresetn (rst_n),
      .bus     (m_if)
   );

   agc_loop_ctrl #(.WINDOW_LEN(4), .SETTLE_LEN(2), .SCALE_INIT(17'h1FF80)) u_sat (
      .aclk    (aclk),
      .aresetn (rst_n),
      .bus     (s_if)
   );

   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_rst = 0, n_tick = 0, n_ce = 0, n_sce = 0, n_oce = 0, n_apply = 0, n_done = 0, n_busy = 0;

   always @(negedge aclk) begin
      if (m_if.agc_rst_o)   n_rst++;
      if (m_if.agc_tick_o)  n_tick++;
      if (m_if.agc_ce_o)    n_ce++;
      if (m_if.scale_ce_o)  n_sce++;
      if (m_if.offset_ce_o) n_oce++;
      if (m_if.apply_o)     n_apply++;
      if (m_if.iter_done_o) n_done++;
      if (m_if.busy_o)      n_busy++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge aclk);
      #1;
   endtask

   // Reference model: one iteration of the loop rules in plain integer arithmetic
   int m_scale = 'h10000;
   int m_ofs   = 0;
   bit m_lock  = 1'b0;

   function automatic void model_iter(input longint sq, input longint tgt, input longint tol,
                                      input longint gt, input longint lt);
      int s0, o0;
      longint hi, lo;
      s0 = m_scale;
      o0 = m_ofs;
      hi = tgt + tol;
      lo = (tgt > tol) ? tgt - tol : 0;
      if (sq > hi)      m_scale = (m_scale >= STEP) ? m_scale - STEP : 0;
      else if (sq < lo) m_scale = (m_scale + STEP > 131071) ? 131071 : m_scale + STEP;
      if (gt > lt + OTOL)      m_ofs = (m_ofs > -128) ? m_ofs - 1 : -128;
      else if (lt > gt + OTOL) m_ofs = (m_ofs < 127) ? m_ofs + 1 : 127;
      m_lock = (m_scale == s0) && (m_ofs == o0);
   endfunction

   task automatic set_inputs(input logic [23:0] sq, input logic [23:0] tgt, input logic [23:0] tol,
                             input logic [20:0] gt, input logic [20:0] lt);
      m_if.sq_accum_i  = sq;
      m_if.sq_target_i = tgt;
      m_if.sq_tol_i    = tol;
      m_if.gt_accum_i  = gt;
      m_if.lt_accum_i  = lt;
   endtask

   // One single_i iteration with full sequencing and result checks
   task automatic do_iter(input logic [23:0] sq, input logic [23:0] tgt, input logic [23:0] tol,
                          input logic [20:0] gt, input logic [20:0] lt,
                          input logic [16:0] e_scale, input logic [7:0] e_ofs, input logic e_lock,
                          input string tag);
      int c_rst, c_tick, c_ce, c_sce, c_oce, c_app, c_done, c_busy, n;
      c_rst = n_rst; c_tick = n_tick; c_ce = n_ce; c_sce = n_sce;
      c_oce = n_oce; c_app = n_apply; c_done = n_done; c_busy = n_busy;
      set_inputs(sq, tgt, tol, gt, lt);
      m_if.single_i = 1'b1;
      step();
      m_if.single_i = 1'b0;
      check({tag, "_clr"}, {m_if.agc_rst_o, m_if.busy_o}, 2'b11);
      step();
      step();
      check({tag, "_ce_start"}, m_if.agc_ce_o, 1'b1);
      n = 0;
      while (!m_if.scale_ce_o && n < 100) begin
         step();
         n++;
      end
      check({tag, "_load_lat"}, n, WLEN + SLEN + 1);
      check({tag, "_scale"}, m_if.scale_o, e_scale);
      check({tag, "_ofs"}, m_if.offset_o, e_ofs);
      check({tag, "_lock"}, m_if.locked_o, e_lock);
      step();
      check({tag, "_apply"}, {m_if.apply_o, m_if.iter_done_o, m_if.scale_o, m_if.offset_o},
            {1'b1, 1'b1, e_scale, e_ofs});
      step();
      check({tag, "_idle"}, m_if.busy_o, 1'b0);
      check({tag, "_pulses"},
            {4'(n_rst - c_rst), 4'(n_tick - c_tick), 4'(n_sce - c_sce), 4'(n_oce - c_oce),
             4'(n_app_diff(c_app)), 4'(n_done - c_done), 8'(n_ce - c_ce), 8'(n_busy - c_busy)},
            {4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 8'(WLEN), 8'(BUSY_CYC)});
   endtask

   function automatic int n_app_diff(input int c);
      return n_apply - c;
   endfunction

   typedef struct {
      logic [23:0] sq, tgt, tol;
      logic [20:0] gt, lt;
      logic [16:0] scale;
      logic [7:0]  ofs;
      logic        lock;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int n, c_done, c_rst, c_app, c_sce, sat_scale;
      logic [23:0] r_sq, r_tgt, r_tol;
      logic [20:0] r_gt, r_lt;
      longint s;

      tbl[0] = '{24'h100000, 24'h080000, 24'h001000, 21'd500,      21'd500,      17'h0FF00, 8'h00, 1'b0};
      tbl[1] = '{24'h080000, 24'h080000, 24'h001000, 21'd500,      21'd500,      17'h0FF00, 8'h00, 1'b1};
      tbl[2] = '{24'h000010, 24'h000100, 24'h001000, 21'd0,        21'd0,        17'h0FF00, 8'h00, 1'b1};
      tbl[3] = '{24'h081000, 24'h080000, 24'h001000, 21'd164,      21'd100,      17'h0FF00, 8'h00, 1'b1};
      tbl[4] = '{24'h081001, 24'h080000, 24'h001000, 21'd165,      21'd100,      17'h0FE00, 8'hFF, 1'b0};
      tbl[5] = '{24'h07F000, 24'h080000, 24'h001000, 21'd100,      21'd165,      17'h0FE00, 8'h00, 1'b0};
      tbl[6] = '{24'h07EFFF, 24'h080000, 24'h001000, 21'd7,        21'd7,        17'h0FF00, 8'h00, 1'b0};
      tbl[7] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 21'h1FFFFF,   21'h1FFFFF,   17'h0FF00, 8'h00, 1'b1};
      tbl[8] = '{24'h000000, 24'h000000, 24'h000000, 21'h1FFFFF,   21'h1FFFC0,   17'h0FF00, 8'h00, 1'b1};
      tbl[9] = '{24'hFFFFFF, 24'h000000, 24'h000000, 21'd0,        21'h1FFFFF,   17'h0FE00, 8'h01, 1'b0};

      m_if.run_i = 1'b0;
      m_if.single_i = 1'b0;
      set_inputs('0, '0, '0, '0, '0);
      s_if.run_i = 1'b0;
      s_if.single_i = 1'b0;
      s_if.sq_accum_i = 24'h0;
      s_if.sq_target_i = 24'h1000;
      s_if.sq_tol_i = 24'h10;
      s_if.gt_accum_i = '0;
      s_if.lt_accum_i = '0;

      // Reset state
      step(); step(); step();
      check("rst_scale", m_if.scale_o, 17'h10000);
      check("rst_flags", {m_if.offset_o, m_if.locked_o, m_if.busy_o, m_if.agc_ce_o, m_if.agc_rst_o,
                          m_if.agc_tick_o, m_if.scale_ce_o, m_if.offset_ce_o, m_if.apply_o, m_if.iter_done_o},
            18'h0);
      rst_n = 1'b1;
      step(); step(); step(); step();
      check("post_rst_idle", m_if.busy_o, 1'b0);

      // Scale saturation at the top on the second instance
      check("sat_init", s_if.scale_o, 17'h1FF80);
      sat_scale = 'h1FF80;
      for (int k = 0; k < 3; k++) begin
         s_if.single_i = 1'b1;
         step();
         s_if.single_i = 1'b0;
         n = 0;
         while (!s_if.apply_o && n < 60) begin
            step();
            n++;
         end
         sat_scale = (sat_scale + STEP > 131071) ? 131071 : sat_scale + STEP;
         check($sformatf("sat_scale_%0d", k), {s_if.apply_o, s_if.scale_o}, {1'b1, 17'(sat_scale)});
         step();
      end

      // Vector table
      foreach (tbl[i]) begin
         do_iter(tbl[i].sq, tbl[i].tgt, tbl[i].tol, tbl[i].gt, tbl[i].lt,
                 tbl[i].scale, tbl[i].ofs, tbl[i].lock, $sformatf("tbl%0d", i));
         model_iter(tbl[i].sq, tbl[i].tgt, tbl[i].tol, tbl[i].gt, tbl[i].lt);
      end

      // Randomized iterations against the model
      for (int i = 0; i < 20; i++) begin
         r_tgt = 24'($urandom_range(0, 24'hFFFFFF));
         r_tol = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 24'hFFFFFF))
                                              : 24'($urandom_range(0, 24'h2000));
         if ($urandom_range(0, 2) == 0) begin
            r_sq = 24'($urandom_range(0, 24'hFFFFFF));
         end else begin
            s = longint'(r_tgt) + longint'($urandom_range(0, 2 * r_tol + 2)) - longint'(r_tol) - 1;
            if (s < 0) s = 0;
            if (s > 64'hFFFFFF) s = 64'hFFFFFF;
            r_sq = 24'(s);
         end
         r_lt = 21'($urandom_range(0, 21'h1FFFFF));
         s = longint'(r_lt) + longint'($urandom_range(0, 260)) - 130;
         if (s < 0) s = 0;
         if (s > 64'h1FFFFF) s = 64'h1FFFFF;
         r_gt = 21'(s);
         model_iter(r_sq, r_tgt, r_tol, r_gt, r_lt);
         do_iter(r_sq, r_tgt, r_tol, r_gt, r_lt, 17'(m_scale), 8'(m_ofs), m_lock,
                 $sformatf("rnd%0d", i));
      end

      // Offset pushed to its negative floor and held there
      for (int i = 0; i < 160; i++) begin
         model_iter(24'h080000, 24'h080000, 24'h001000, 1000, 100);
         do_iter(24'h080000, 24'h080000, 24'h001000, 21'd1000, 21'd100,
                 17'(m_scale), 8'(m_ofs), m_lock, $sformatf("ofs_sat%0d", i));
      end
      check("ofs_floor", m_if.offset_o, 8'h80);

      // Continuous run, dropped during the fourth window
      set_inputs(24'h100000, 24'h080000, 24'h001000, 21'd500, 21'd500);
      c_done = n_done;
      c_rst  = n_rst;
      m_if.run_i = 1'b1;
      n = 0;
      while ((n_done - c_done) < 3 && n < 200) begin
         step();
         n++;
      end
      n = 0;
      while (!m_if.agc_ce_o && n < 20) begin
         step();
         n++;
      end
      m_if.run_i = 1'b0;
      n = 0;
      while (m_if.busy_o && n < 200) begin
         step();
         n++;
      end
      for (int k = 0; k < 5; k++) step();
      for (int k = 0; k < 4; k++) model_iter(24'h100000, 24'h080000, 24'h001000, 500, 500);
      check("run_iters", {8'(n_done - c_done), 8'(n_rst - c_rst)}, {8'd4, 8'd4});
      check("run_idle", m_if.busy_o, 1'b0);
      check("run_scale", m_if.scale_o, 17'(m_scale));
      check("run_lock", m_if.locked_o, m_lock);

      // single_i while busy (in MEASURE and in APPLY) is dropped
      c_rst = n_rst;
      c_app = n_apply;
      set_inputs(24'h000100, 24'h080000, 24'h001000, 21'd100, 21'd500);
      m_if.single_i = 1'b1;
      step();
      m_if.single_i = 1'b0;
      step(); step(); step(); step();
      m_if.single_i = 1'b1;
      step();
      m_if.single_i = 1'b0;
      n = 0;
      while (!m_if.scale_ce_o && n < 100) begin
         step();
         n++;
      end
      step();
      m_if.single_i = 1'b1;
      step();
      m_if.single_i = 1'b0;
      for (int k = 0; k < 40; k++) step();
      model_iter(24'h000100, 24'h080000, 24'h001000, 100, 500);
      check("busy_single_ign", {8'(n_rst - c_rst), 8'(n_apply - c_app), 7'd0, m_if.busy_o},
            {8'd1, 8'd1, 8'd0});
      check("busy_single_res", {m_if.scale_o, m_if.offset_o}, {17'(m_scale), 8'(m_ofs)});

      // Reset asserted in the middle of MEASURE
      m_if.single_i = 1'b1;
      step();
      m_if.single_i = 1'b0;
      for (int k = 0; k < 7; k++) step();
      check("mid_ce_before", m_if.agc_ce_o, 1'b1);
      c_app = n_apply;
      c_sce = n_sce;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ce", {m_if.agc_ce_o, m_if.busy_o, m_if.locked_o}, 3'b000);
      check("mid_rst_scale", {m_if.scale_o, m_if.offset_o}, {17'h10000, 8'h00});
      step(); step(); step();
      rst_n = 1'b1;
      for (int k = 0; k < 60; k++) step();
      check("mid_rst_no_apply", {8'(n_apply - c_app), 8'(n_sce - c_sce), 7'd0, m_if.busy_o},
            {8'd0, 8'd0, 8'd0});

      // Recovery after reset
      m_scale = 'h10000;
      m_ofs   = 0;
      model_iter(24'h100000, 24'h080000, 24'h001000, 500, 500);
      do_iter(24'h100000, 24'h080000, 24'h001000, 21'd500, 21'd500,
              17'(m_scale), 8'(m_ofs), m_lock, "recover");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
